// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a two-state data-memory access tracker.
// Holds the MEM entry while memory is busy and counts stall cycles.
module ex_mem_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        EX_valid,
  input  logic [31:0] EX_aluResult,
  input  logic [31:0] EX_rs2Data,
  input  logic [4:0]  EX_rd,
  input  logic        EX_regWrite,
  input  logic        EX_memRead,
  input  logic        EX_memWrite,
  input  logic        EX_memToReg,
  input  logic [2:0]  EX_funct3,
  input  logic        flush,
  input  logic        dmem_ready,
  output logic        EX_MEMvalid,
  output logic [31:0] EX_MEMaluResult,
  output logic [31:0] EX_MEMstoreData,
  output logic [4:0]  EX_MEMrd,
  output logic        EX_MEMregWrite,
  output logic        EX_MEMmemRead,
  output logic        EX_MEMmemWrite,
  output logic        EX_MEMmemToReg,
  output logic [2:0]  EX_MEMfunct3,
  output logic        dmem_req,
  output logic        memStall,
  output logic [15:0] stallCount
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;
  logic   take;
  logic   mem_op;

  assign dmem_req = (state == ACCESS);
  assign memStall = dmem_req && !dmem_ready;

  // a flushed or invalid entry becomes a fully zeroed bubble
  assign take   = !flush && EX_valid;
  assign mem_op = take && (EX_memRead || EX_memWrite);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      EX_MEMvalid     <= 1'b0;
      EX_MEMaluResult <= '0;
      EX_MEMstoreData <= '0;
      EX_MEMrd        <= '0;
      EX_MEMregWrite  <= 1'b0;
      EX_MEMmemRead   <= 1'b0;
      EX_MEMmemWrite  <= 1'b0;
      EX_MEMmemToReg  <= 1'b0;
      EX_MEMfunct3    <= '0;
      state           <= IDLE;
      stallCount      <= '0;
    end else if (memStall) begin
      if (stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
    end else begin
      EX_MEMvalid     <= take;
      EX_MEMaluResult <= take ? EX_aluResult : '0;
      EX_MEMstoreData <= take ? EX_rs2Data : '0;
      EX_MEMrd        <= take ? EX_rd : '0;
      EX_MEMregWrite  <= take && EX_regWrite;
      EX_MEMmemRead   <= take && EX_memRead;
      EX_MEMmemWrite  <= take && EX_memWrite;
      EX_MEMmemToReg  <= take && EX_memToReg;
      EX_MEMfunct3    <= take ? EX_funct3 : '0;
      // zero-bubble handoff: a new access opens on the completing edge
      state           <= mem_op ? ACCESS : IDLE;
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: per-cycle reference model plus
// hand-computed checkpoints for each scenario.
module tb_ex_mem_reg;

  logic        clk;
  logic        reset_n;
  logic        EX_valid;
  logic [31:0] EX_aluResult;
  logic [31:0] EX_rs2Data;
  logic [4:0]  EX_rd;
  logic        EX_regWrite;
  logic        EX_memRead;
  logic        EX_memWrite;
  logic        EX_memToReg;
  logic [2:0]  EX_funct3;
  logic        flush;
  logic        dmem_ready;
  logic        EX_MEMvalid;
  logic [31:0] EX_MEMaluResult;
  logic [31:0] EX_MEMstoreData;
  logic [4:0]  EX_MEMrd;
  logic        EX_MEMregWrite;
  logic        EX_MEMmemRead;
  logic        EX_MEMmemWrite;
  logic        EX_MEMmemToReg;
  logic [2:0]  EX_MEMfunct3;
  logic        dmem_req;
  logic        memStall;
  logic [15:0] stallCount;

  int total;
  int bad;

  ex_mem_reg dut (
    .clk(clk),
    .reset_n(reset_n),
    .EX_valid(EX_valid),
    .EX_aluResult(EX_aluResult),
    .EX_rs2Data(EX_rs2Data),
    .EX_rd(EX_rd),
    .EX_regWrite(EX_regWrite),
    .EX_memRead(EX_memRead),
    .EX_memWrite(EX_memWrite),
    .EX_memToReg(EX_memToReg),
    .EX_funct3(EX_funct3),
    .flush(flush),
    .dmem_ready(dmem_ready),
    .EX_MEMvalid(EX_MEMvalid),
    .EX_MEMaluResult(EX_MEMaluResult),
    .EX_MEMstoreData(EX_MEMstoreData),
    .EX_MEMrd(EX_MEMrd),
    .EX_MEMregWrite(EX_MEMregWrite),
    .EX_MEMmemRead(EX_MEMmemRead),
    .EX_MEMmemWrite(EX_MEMmemWrite),
    .EX_MEMmemToReg(EX_MEMmemToReg),
    .EX_MEMfunct3(EX_MEMfunct3),
    .dmem_req(dmem_req),
    .memStall(memStall),
    .stallCount(stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the pipeline slot is frozen while a memory access is
  // outstanding and unanswered; otherwise it takes the EX entry (or a
  // bubble), and any accepted load/store opens a new access.
  logic        m_valid, m_rw, m_mr, m_mw, m_m2r;
  logic [31:0] m_alu, m_sd;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic        m_busy;
  int          m_cnt;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    bit ok;
    if (!reset_n) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r} = '0;
      m_alu = 0; m_sd = 0; m_rd = 0; m_f3 = 0;
      m_busy = 1'b0;
      m_cnt = 0;
      armed = 1'b1;
    end else if (m_busy && !dmem_ready) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      ok = EX_valid && !flush;
      m_valid = ok;
      m_alu = ok ? EX_aluResult : 32'h0;
      m_sd  = ok ? EX_rs2Data : 32'h0;
      m_rd  = ok ? EX_rd : 5'h0;
      m_f3  = ok ? EX_funct3 : 3'h0;
      m_rw  = ok && EX_regWrite;
      m_mr  = ok && EX_memRead;
      m_mw  = ok && EX_memWrite;
      m_m2r = ok && EX_memToReg;
      m_busy = m_mr || m_mw;
    end
    #1;
    if (armed) begin
      chk("valid", EX_MEMvalid, m_valid);
      chk("alu", EX_MEMaluResult, m_alu);
      chk("sdata", EX_MEMstoreData, m_sd);
      chk("rd", EX_MEMrd, m_rd);
      chk("regw", EX_MEMregWrite, m_rw);
      chk("memr", EX_MEMmemRead, m_mr);
      chk("memw", EX_MEMmemWrite, m_mw);
      chk("m2r", EX_MEMmemToReg, m_m2r);
      chk("f3", EX_MEMfunct3, m_f3);
      chk("req", dmem_req, m_busy);
      chk("stall", memStall, m_busy && !dmem_ready);
      chk("cnt", stallCount, m_cnt[15:0]);
      chk("ctl_gate", (EX_MEMregWrite | EX_MEMmemRead | EX_MEMmemWrite)
          & ~EX_MEMvalid, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu,
                        input logic [31:0] sd, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw,
                        input logic m2r, input logic [2:0] f3);
    EX_valid = v; EX_aluResult = alu; EX_rs2Data = sd; EX_rd = rd;
    EX_regWrite = rw; EX_memRead = mr; EX_memWrite = mw;
    EX_memToReg = m2r; EX_funct3 = f3;
  endtask

  task automatic idle();
    set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    int reqs;
    int stalls;
    total = 0;
    bad = 0;
    reset_n = 1'b0;
    flush = 1'b0;
    dmem_ready = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_valid", EX_MEMvalid, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_cnt", stallCount, 16'd0);
    reset_n = 1'b1;
    dmem_ready = 1'b0;

    // ALU op
    set_ex(1'b1, 32'hAA, 32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk("alu_rd", EX_MEMrd, 5'd5);
    chk("alu_rw", EX_MEMregWrite, 1'b1);
    chk("alu_res", EX_MEMaluResult, 32'hAA);
    chk("alu_req", dmem_req, 1'b0);

    // load with three wait cycles
    set_ex(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
    tick();
    idle();
    reqs = 0;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      reqs += int'(dmem_req);
      stalls += int'(memStall);
      chk("ld_hold_rd", EX_MEMrd, 5'd7);
      tick();
    end
    dmem_ready = 1'b0;
    chk("ld_reqs", reqs, 4);
    chk("ld_stalls", stalls, 3);
    chk("ld_cnt", stallCount, 16'd3);
    chk("ld_idle", dmem_req, 1'b0);

    // flush of a valid entry
    flush = 1'b1;
    set_ex(1'b1, 32'h55, 32'h66, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    tick();
    chk("fl_valid", EX_MEMvalid, 1'b0);
    chk("fl_rw", EX_MEMregWrite, 1'b0);
    chk("fl_rd", EX_MEMrd, 5'd0);
    flush = 1'b0;

    // invalid entry gates controls; rd=0 passes through
    set_ex(1'b0, 32'h77, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    tick();
    chk("inv_req", dmem_req, 1'b0);
    chk("inv_memr", EX_MEMmemRead, 1'b0);
    set_ex(1'b1, 32'h9, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    chk("x0_rw", EX_MEMregWrite, 1'b1);
    chk("x0_alu", EX_MEMaluResult, 32'h9);

    // flush held across a stalled store
    set_ex(1'b1, 32'h200, 32'hDEAD, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
    tick();
    flush = 1'b1;
    set_ex(1'b1, 32'h300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    tick();
    chk("fs_hold_mw", EX_MEMmemWrite, 1'b1);
    chk("fs_hold_sd", EX_MEMstoreData, 32'hDEAD);
    dmem_ready = 1'b1;
    tick();
    chk("fs_bubble", EX_MEMvalid, 1'b0);
    chk("fs_idle", dmem_req, 1'b0);
    chk("fs_cnt", stallCount, 16'd5);
    flush = 1'b0;
    dmem_ready = 1'b0;

    // reset in the middle of an access
    set_ex(1'b1, 32'h400, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    tick();
    idle();
    chk("mr_req", dmem_req, 1'b1);
    chk("mr_cnt", stallCount, 16'd5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mr_req0", dmem_req, 1'b0);
    chk("mr_stall0", memStall, 1'b0);
    chk("mr_cnt0", stallCount, 16'd0);
    chk("mr_rd0", EX_MEMrd, 5'd0);

    // store then load back to back
    set_ex(1'b1, 32'h500, 32'hBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2);
    tick();
    set_ex(1'b1, 32'h504, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
    dmem_ready = 1'b1;
    #1;
    chk("bb_nostall", memStall, 1'b0);
    tick();
    idle();
    chk("bb_req", dmem_req, 1'b1);
    chk("bb_ld_rd", EX_MEMrd, 5'd11);
    chk("bb_ld_mr", EX_MEMmemRead, 1'b1);
    tick();
    chk("bb_done", dmem_req, 1'b0);
    chk("bb_cnt", stallCount, 16'd0);
    dmem_ready = 1'b0;

    // saturation of the stall counter
    set_ex(1'b1, 32'h600, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
    tick();
    idle();
    repeat (65540) tick();
    chk("sat_cnt", stallCount, 16'hFFFF);
    dmem_ready = 1'b1;
    tick();
    chk("sat_idle", dmem_req, 1'b0);
    chk("sat_keep", stallCount, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have inputs EX_valid (1), EX_aluResult (32), EX_rs2Data (32), EX_rd (5), EX_regWrite (1), EX_memRead (1), EX_memWrite (1), EX_memToReg (1), EX_funct3 (3): EX-stage results and controls.
REQ-004 SHALL have input flush (1): replace the incoming EX entry with a bubble.
REQ-005 SHALL have input dmem_ready (1): data memory has completed the current access this cycle.
REQ-006 SHALL have outputs EX_MEMvalid (1), EX_MEMaluResult (32), EX_MEMstoreData (32), EX_MEMrd (5), EX_MEMregWrite (1), EX_MEMmemRead (1), EX_MEMmemWrite (1), EX_MEMmemToReg (1), EX_MEMfunct3 (3): registered MEM-stage entry, consumed by the forwarding unit and the MEM stage.
REQ-007 SHALL have outputs dmem_req (1), memStall (1), stallCount (16): memory request, upstream stall, and saturating count of stall cycles.

Function
REQ-008 SHALL capture all EX_* inputs into the EX_MEM* registers on a rising edge when memStall=0 and flush=0.
REQ-009 SHALL load a bubble on a rising edge when memStall=0 and flush=1: EX_MEMvalid=0, EX_MEMregWrite=0, EX_MEMmemRead=0, EX_MEMmemWrite=0, EX_MEMmemToReg=0; data, rd and funct3 fields SHALL be zero.
REQ-010 SHALL hold every EX_MEM* register unchanged while memStall=1, regardless of flush or EX_* inputs; upstream holds flush asserted until the stall clears.
REQ-011 SHALL gate control on capture: EX_MEMregWrite, EX_MEMmemRead, EX_MEMmemWrite = corresponding EX_* AND EX_valid; with EX_valid=0, a bubble is stored as in REQ-009.
REQ-012 SHALL pass EX_rd = 0 through unmodified; x0 filtering is done downstream.
REQ-013 SHALL implement a 2-state FSM, IDLE and ACCESS.
REQ-014 SHALL go IDLE->ACCESS on an edge that captures an entry with memRead or memWrite set after gating.
REQ-015 SHALL, in ACCESS with dmem_ready=1, go to ACCESS if the same edge captures another memory op, else to IDLE.
REQ-016 SHALL stay in ACCESS while dmem_ready=0.
REQ-017 SHALL drive dmem_req = (state==ACCESS), combinational from state.
REQ-018 SHALL drive memStall = (state==ACCESS) AND NOT dmem_ready, combinational; no latency from dmem_ready to memStall deassertion.
REQ-019 SHALL capture normally per REQ-008/009 on the edge where ACCESS sees dmem_ready=1; this is a zero-bubble handoff.
REQ-020 SHALL ignore dmem_ready in IDLE.
REQ-021 SHALL increment stallCount by 1 on each edge with memStall=1, saturating at 16'hFFFF with no wrap.
REQ-022 SHALL never assert EX_MEMregWrite, EX_MEMmemRead or EX_MEMmemWrite while EX_MEMvalid=0.

Reset
REQ-023 SHALL, on an edge with reset_n=0, clear all EX_MEM* outputs to 0, set state to IDLE, and clear stallCount to 0, overriding stall and flush.
REQ-024 SHALL abandon an in-progress access when reset occurs mid-ACCESS: dmem_req=0 and memStall=0 from the next cycle.
REQ-025 SHALL not drive dmem_req or memStall high during reset; both derive from state=IDLE.

Verification
REQ-026 Reset then ALU op (EX_valid=1, rd=5, regWrite=1, aluResult=32'h0000_00AA) -> next cycle EX_MEMrd=5, EX_MEMregWrite=1, EX_MEMaluResult=32'hAA, dmem_req=0.
REQ-027 Load (memRead=1, rd=7), dmem_ready=0 for 3 cycles then 1 -> dmem_req high 4 cycles, memStall high 3 cycles, entry held throughout, stallCount=3, FSM returns to IDLE.
REQ-028 Flush=1 with a valid regWrite entry presented, no stall -> EX_MEMvalid=0, EX_MEMregWrite=0, EX_MEMrd=0.
REQ-029 Flush=1 during memStall -> registers unchanged; bubble loaded on the first edge after dmem_ready=1.
REQ-030 Back-to-back store then load, dmem_ready=1 on the store's first ACCESS cycle -> FSM stays ACCESS, load captured with no bubble, dmem_req continuous.
REQ-031 reset_n=0 mid-ACCESS with stallCount=5 -> next cycle all outputs 0, state IDLE, stallCount=0.
